// File: rtl/periph_bridge_if.sv
// periph_bridge_if
// Bundles the core load/store port and the shared peripheral bus of the
// periph_bridge into one interface.
//   Core side      : lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i (to bridge)
//                    lsu_rdata_o, lsu_stall_o (from bridge)
//   Peripheral side: req_o[3:0], we_o, addr_o, wdata_o (from bridge)
//                    dev0_rdata_i .. dev3_rdata_i (to bridge)
// Modports:
//   master - the bridge's view (it masters the peripheral bus)
//   slave  - the environment's view (core plus devices)
interface periph_bridge_if;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_stall_o;

    logic [3:0]  req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [31:0] dev0_rdata_i;
    logic [31:0] dev1_rdata_i;
    logic [31:0] dev2_rdata_i;
    logic [31:0] dev3_rdata_i;

    modport master (
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
        input  dev0_rdata_i, dev1_rdata_i, dev2_rdata_i, dev3_rdata_i,
        output lsu_rdata_o, lsu_stall_o,
        output req_o, we_o, addr_o, wdata_o
    );

    modport slave (
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
        output dev0_rdata_i, dev1_rdata_i, dev2_rdata_i, dev3_rdata_i,
        input  lsu_rdata_o, lsu_stall_o,
        input  req_o, we_o, addr_o, wdata_o
    );
endinterface

// File: rtl/periph_bridge.sv
// periph_bridge
// Bridges core load/store requests into a four-device peripheral bus.
// Requests whose address top byte equals REGION are claimed; bits [19:16]
// pick the device. Devices 0-3 get a one-cycle one-hot request and answer
// one cycle later; devices 4-15 are unmapped and return ERR_DATA at once,
// bumping a saturating error counter.
// Ports:
//   CLK100    - clock, rising edge
//   resetn    - synchronous active-low reset
//   bus       - periph_bridge_if.master (core port + peripheral bus)
//   err_cnt_o - saturating count of unmapped-device accesses
module periph_bridge #(
    parameter logic [7:0]  REGION   = 8'h80,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              CLK100,
    input  logic              resetn,
    periph_bridge_if.master   bus,
    output logic [7:0]        err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        hit;
    logic        mapped;
    logic [3:0]  dev_idx;
    logic [1:0]  sel;
    logic        accept;
    logic        reject;
    logic        capture;
    logic [31:0] dev_rdata;

    assign hit     = (bus.lsu_addr_i[31:24] == REGION);
    assign dev_idx = bus.lsu_addr_i[19:16];
    assign mapped  = (dev_idx < 4'd4);

    // Next-state and control decode. The stall is combinational so the core
    // sees it in the same cycle it raises a region request; requests outside
    // the region are never stalled and never leave IDLE.
    always_comb begin
        next_state      = state;
        accept          = 1'b0;
        reject          = 1'b0;
        capture         = 1'b0;
        bus.lsu_stall_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.lsu_req_i && hit) begin
                    bus.lsu_stall_o = 1'b1;
                    if (mapped) begin
                        accept     = 1'b1;
                        next_state = REQ;
                    end else begin
                        reject     = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            REQ: begin
                bus.lsu_stall_o = 1'b1;
                next_state      = WAIT;
            end
            WAIT: begin
                bus.lsu_stall_o = 1'b1;
                capture         = 1'b1;
                next_state      = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read-data select uses the device index latched at accept time, so the
    // core changing its address mid-transaction cannot redirect the capture.
    always_comb begin
        dev_rdata = bus.dev0_rdata_i;
        unique case (sel)
            2'd0: dev_rdata = bus.dev0_rdata_i;
            2'd1: dev_rdata = bus.dev1_rdata_i;
            2'd2: dev_rdata = bus.dev2_rdata_i;
            2'd3: dev_rdata = bus.dev3_rdata_i;
            default: dev_rdata = bus.dev0_rdata_i;
        endcase
    end

    // State register.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers. req_o defaults low every cycle, so the one-hot
    // pulse set on accept lasts exactly the REQ cycle. Reset wins over a
    // pending capture, which is what aborts an in-flight transaction.
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            bus.req_o       <= '0;
            bus.we_o        <= 1'b0;
            bus.addr_o      <= '0;
            bus.wdata_o     <= '0;
            bus.lsu_rdata_o <= '0;
            err_cnt_o       <= '0;
            sel             <= '0;
        end else begin
            bus.req_o <= '0;
            if (accept) begin
                bus.we_o    <= bus.lsu_we_i;
                bus.addr_o  <= bus.lsu_addr_i;
                bus.wdata_o <= bus.lsu_wdata_i;
                sel         <= dev_idx[1:0];
                bus.req_o   <= 4'b0001 << dev_idx[1:0];
            end
            if (reject) begin
                bus.lsu_rdata_o <= ERR_DATA;
                if (err_cnt_o != 8'hFF) begin
                    err_cnt_o <= err_cnt_o + 8'd1;
                end
            end
            if (capture) begin
                bus.lsu_rdata_o <= dev_rdata;
            end
        end
    end

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge
// Self-checking bench for periph_bridge. Drives core requests, models four
// devices that answer one cycle after their request, and compares each
// completed transfer against an expectation queued when it was issued.
module tb_periph_bridge;

    logic CLK100;
    logic resetn;
    logic [7:0] err_cnt_o;

    periph_bridge_if bus();

    periph_bridge #(
        .REGION   (8'h80),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .CLK100    (CLK100),
        .resetn    (resetn),
        .bus       (bus),
        .err_cnt_o (err_cnt_o)
    );

    typedef struct {
        logic [3:0]  reqMask;
        int          latency;
        int          pulses;
        logic [31:0] rdata;
        logic [7:0]  errCnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } expect_t;

    expect_t     sbQueue[$];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          lastPulseCycle = 0;
    logic [31:0] devBase = 32'h0;
    logic [31:0] modelRdata = 32'h0;
    logic [7:0]  modelErr = 8'h0;

    // 100 MHz-style free-running clock.
    initial begin
        CLK100 = 1'b0;
        forever #5 CLK100 = ~CLK100;
    end

    always @(posedge CLK100) cycleCount <= cycleCount + 1;

    // Device models: each answers one cycle after its request with a value
    // unique to the device, and drives zero otherwise so a mistimed capture
    // shows up as wrong data.
    always @(posedge CLK100) begin
        bus.dev0_rdata_i <= bus.req_o[0] ? devBase + 32'd0 : 32'h0;
        bus.dev1_rdata_i <= bus.req_o[1] ? devBase + 32'd1 : 32'h0;
        bus.dev2_rdata_i <= bus.req_o[2] ? devBase + 32'd2 : 32'h0;
        bus.dev3_rdata_i <= bus.req_o[3] ? devBase + 32'd3 : 32'h0;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Issue one core request, push its expectation, then follow it until the
    // stall drops and compare against the popped expectation. The request is
    // left asserted so a following call gives a back-to-back access.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit perturb);
        expect_t     e;
        expect_t     got;
        logic [3:0]  idx;
        bit          done;
        int          n;
        idx = addr[19:16];
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        if (addr[31:24] != 8'h80) begin
            e.reqMask = 4'b0000;
            e.latency = 0;
            e.pulses  = 0;
        end else if (idx < 4'd4) begin
            e.reqMask  = 4'b0001 << idx[1:0];
            e.latency  = 3;
            e.pulses   = 1;
            modelRdata = devBase + {30'd0, idx[1:0]};
        end else begin
            e.reqMask  = 4'b0000;
            e.latency  = 1;
            e.pulses   = 0;
            modelRdata = 32'hDEAD_BEEF;
            if (modelErr != 8'hFF) modelErr = modelErr + 8'd1;
        end
        e.rdata  = modelRdata;
        e.errCnt = modelErr;
        sbQueue.push_back(e);

        @(posedge CLK100);
        #1;
        bus.lsu_req_i   = 1'b1;
        bus.lsu_we_i    = we;
        bus.lsu_addr_i  = addr;
        bus.lsu_wdata_i = wdata;

        done = 0;
        n = 0;
        got.reqMask = 4'b0000;
        got.pulses = 0;
        got.we = 1'b0;
        got.addr = 32'h0;
        got.wdata = 32'h0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge CLK100);
            if (bus.req_o != 4'b0000) begin
                got.pulses++;
                got.reqMask    = bus.req_o;
                got.we         = bus.we_o;
                got.addr       = bus.addr_o;
                got.wdata      = bus.wdata_o;
                lastPulseCycle = cycleCount;
            end
            if (!bus.lsu_stall_o) begin
                done = 1;
                n = c;
            end else begin
                @(posedge CLK100);
                #1;
                if (perturb) begin
                    bus.lsu_we_i    = ~we;
                    bus.lsu_addr_i  = 32'h8003_0FFC;
                    bus.lsu_wdata_i = ~wdata;
                end
            end
        end
        if (!done) checkOutput("stallTimeout", 32'd0, 32'd1);

        e = sbQueue.pop_front();
        checkOutput("latency", n, e.latency);
        checkOutput("reqMask", {28'd0, got.reqMask}, {28'd0, e.reqMask});
        checkOutput("reqPulses", got.pulses, e.pulses);
        if (e.pulses != 0) begin
            checkOutput("weOut", {31'd0, got.we}, {31'd0, e.we});
            checkOutput("addrOut", got.addr, e.addr);
            checkOutput("wdataOut", got.wdata, e.wdata);
        end
        checkOutput("rdata", bus.lsu_rdata_o, e.rdata);
        checkOutput("errCnt", {24'd0, err_cnt_o}, {24'd0, e.errCnt});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK100);
            #1;
            bus.lsu_req_i = 1'b0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"}, {28'd0, bus.req_o}, 32'd0);
        checkOutput({tag, "_we"}, {31'd0, bus.we_o}, 32'd0);
        checkOutput({tag, "_addr"}, bus.addr_o, 32'd0);
        checkOutput({tag, "_wdata"}, bus.wdata_o, 32'd0);
        checkOutput({tag, "_rdata"}, bus.lsu_rdata_o, 32'd0);
        checkOutput({tag, "_err"}, {24'd0, err_cnt_o}, 32'd0);
        checkOutput({tag, "_stall"}, {31'd0, bus.lsu_stall_o}, 32'd0);
    endtask

    initial begin
        int firstPulse;
        resetn          = 1'b0;
        bus.lsu_req_i   = 1'b0;
        bus.lsu_we_i    = 1'b0;
        bus.lsu_addr_i  = 32'h0;
        bus.lsu_wdata_i = 32'h0;

        $display("[TB] reset");
        repeat (2) @(posedge CLK100);
        @(negedge CLK100);
        checkAllZero("reset");
        @(posedge CLK100);
        #1;
        resetn = 1'b1;

        $display("[TB] write to device 0");
        devBase = 32'h1000_0000;
        applyStimulus(1'b1, 32'h8000_0800, 32'h0000_00A5, 1'b0);
        idleCycles(2);

        $display("[TB] read from device 2");
        devBase = 32'h0000_1232;
        applyStimulus(1'b0, 32'h8002_0F00, 32'h0, 1'b0);
        idleCycles(1);

        $display("[TB] request outside region");
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK100);
            checkOutput("nonHitStall", {31'd0, bus.lsu_stall_o}, 32'd0);
            checkOutput("nonHitReq", {28'd0, bus.req_o}, 32'd0);
        end
        idleCycles(1);

        $display("[TB] unmapped read");
        applyStimulus(1'b0, 32'h8007_0000, 32'h0, 1'b0);
        idleCycles(1);

        $display("[TB] back-to-back reads devices 1 then 3");
        devBase = 32'hCAFE_0000;
        applyStimulus(1'b0, 32'h8001_0010, 32'h0, 1'b0);
        firstPulse = lastPulseCycle;
        applyStimulus(1'b0, 32'h8003_0020, 32'h0, 1'b0);
        checkOutput("b2bGap", lastPulseCycle - firstPulse, 32'd4);
        idleCycles(1);

        $display("[TB] inputs change while transaction in flight");
        devBase = 32'h5A5A_0000;
        applyStimulus(1'b1, 32'h8001_0444, 32'h1357_9BDF, 1'b1);
        idleCycles(1);

        $display("[TB] random mapped transfers");
        for (int i = 0; i < 8; i++) begin
            devBase = $urandom;
            applyStimulus(1'($urandom_range(0, 1)),
                          {8'h80, 4'h0, 2'b00, 2'($urandom_range(0, 3)), 16'($urandom)},
                          $urandom, 1'b0);
        end
        idleCycles(1);

        $display("[TB] reset during WAIT");
        devBase = 32'h7777_0000;
        @(posedge CLK100);
        #1;
        bus.lsu_req_i  = 1'b1;
        bus.lsu_we_i   = 1'b0;
        bus.lsu_addr_i = 32'h8001_0000;
        repeat (2) begin
            @(posedge CLK100);
            #1;
        end
        resetn        = 1'b0;
        bus.lsu_req_i = 1'b0;
        @(negedge CLK100);
        checkOutput("waitStall", {31'd0, bus.lsu_stall_o}, 32'd1);
        @(negedge CLK100);
        checkAllZero("abort");
        modelRdata = 32'h0;
        modelErr   = 8'h0;
        @(posedge CLK100);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100);
            checkOutput("postAbortReq", {28'd0, bus.req_o}, 32'd0);
            checkOutput("postAbortRdata", bus.lsu_rdata_o, 32'd0);
        end

        $display("[TB] 300 unmapped reads");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 32'h8007_0000, 32'h0, 1'b0);
        end
        checkOutput("errSaturated", {24'd0, err_cnt_o}, 32'h0000_00FF);
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
